// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: state encoding,
// parameter defaults and the read data returned on a timeout abort.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIfBusy  = 2'd1,
      StMemBusy = 2'd2,
      StIfDrop  = 2'd3
   } arb_state_e;

   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned TIMEOUT_DEF      = 64;
   localparam logic [31:0] ERR_RDATA        = 32'h0;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-transaction wait counter; flags the last cycle allowed before a
// transaction is aborted for lack of ram_ready.
module mem_arb_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clr) begin
         wait_cnt_d = 8'd0;
      end else if (en) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= 8'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign expired = (wait_cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with MEM
// priority, bounded IF starvation, fetch cancel and a watchdog abort.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_cancel,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic        if_stall,
   output logic        mem_stall,
   output logic        bus_err
);

   arb_state_e  state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        bus_err_q, bus_err_d;
   logic        mem_req, busy, expired, timer_clr, timeout;

   assign mem_req = mem_rd | mem_wr;
   assign busy    = (state_q != StIdle);
   assign timeout = busy & ~ram_ready & expired;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .en      (busy & ~ram_ready),
      .expired (expired)
   );

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      bus_err_d    = bus_err_q | timeout;
      timer_clr    = 1'b0;
      if_ack       = 1'b0;
      mem_ack      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_req && (!if_req || (starve_cnt_q < 4'(STARVE_LIMIT)))) begin
               state_d      = StMemBusy;
               starve_cnt_d = if_req ? starve_cnt_q + 4'd1 : 4'd0;
               addr_d       = mem_addr;
               wdata_d      = mem_wdata;
               we_d         = mem_wr;
               timer_clr    = 1'b1;
            end else if (if_req && !if_cancel) begin
               state_d      = StIfBusy;
               starve_cnt_d = 4'd0;
               addr_d       = if_addr;
               wdata_d      = 32'h0;
               we_d         = 1'b0;
               timer_clr    = 1'b1;
            end
         end
         StIfBusy: begin
            if (ram_ready || expired) begin
               if_ack  = ~if_cancel;
               state_d = StIdle;
            end else if (if_cancel) begin
               // Memory access can't be aborted; drain it silently.
               state_d = StIfDrop;
            end
         end
         StMemBusy: begin
            if (ram_ready || expired) begin
               mem_ack = 1'b1;
               state_d = StIdle;
            end
         end
         StIfDrop: begin
            if (ram_ready || expired) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         starve_cnt_q <= 4'd0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         we_q         <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         bus_err_q    <= bus_err_d;
      end
   end

   // Ready beats a coincident timeout, so real data is returned then.
   assign if_rdata  = ram_ready ? ram_rdata : ERR_RDATA;
   assign mem_rdata = ram_ready ? ram_rdata : ERR_RDATA;
   assign ram_en    = busy;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign bus_err   = bus_err_q;
   assign if_stall  = if_req & ~if_ack;
   assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of
// the arbitration, latency, cancel and watchdog rules.
module tb_mem_port_arbiter;

   localparam int unsigned SL = 4;
   localparam int unsigned TO = 8;
   localparam int          NCYC = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, if_cancel = 1'b0, if_ack;
   logic [31:0] if_addr = '0, if_rdata;
   logic        mem_rd = 1'b0, mem_wr = 1'b0, mem_ack;
   logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
   logic        ram_en, ram_we, ram_ready = 1'b0;
   logic [31:0] ram_addr, ram_wdata, ram_rdata = '0;
   logic        if_stall, mem_stall, bus_err;

   mem_port_arbiter #(
      .STARVE_LIMIT (SL),
      .TIMEOUT      (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_cancel (if_cancel),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ready (ram_ready),
      .if_stall  (if_stall),
      .mem_stall (mem_stall),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: one outstanding transaction described by owner and elapsed wait.
   bit          m_busy, m_fetch, m_discard, m_err, m_we;
   int          m_waited, m_starve;
   logic [31:0] m_addr, m_wdata;
   bit          e_hit, e_tout, e_done, e_if_ack, e_mem_ack;
   int          req_pct, ready_pct;

   task automatic model_reset();
      m_busy = 0; m_fetch = 0; m_discard = 0; m_err = 0; m_we = 0;
      m_waited = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
      e_hit = 0; e_tout = 0; e_done = 0; e_if_ack = 0; e_mem_ack = 0;
   endtask

   task automatic drive();
      if (if_req && (e_if_ack || if_cancel)) if_req = 1'b0;
      if (!if_req && ($urandom_range(99) < req_pct)) begin
         if_req  = 1'b1;
         if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_cancel = if_req && ($urandom_range(15) == 0);
      if ((mem_rd || mem_wr) && e_mem_ack) begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
      if (!(mem_rd || mem_wr) && ($urandom_range(99) < req_pct)) begin
         if ($urandom_range(1) == 1) mem_wr = 1'b1;
         else mem_rd = 1'b1;
         mem_addr  = $urandom;
         mem_wdata = $urandom;
      end
      ram_ready = ($urandom_range(99) < ready_pct);
      ram_rdata = $urandom;
   endtask

   task automatic check_cycle();
      e_hit     = m_busy && ram_ready;
      e_tout    = m_busy && !ram_ready && (m_waited == int'(TO) - 1);
      e_done    = e_hit || e_tout;
      e_if_ack  = e_done && m_fetch && !m_discard && !if_cancel;
      e_mem_ack = e_done && !m_fetch;
      check_val("ram_en", ram_en, m_busy);
      check_val("if_ack", if_ack, e_if_ack);
      check_val("mem_ack", mem_ack, e_mem_ack);
      check_val("if_stall", if_stall, if_req && !e_if_ack);
      check_val("mem_stall", mem_stall, (mem_rd || mem_wr) && !e_mem_ack);
      check_val("bus_err", bus_err, m_err);
      if (m_busy) begin
         check_val("ram_addr", ram_addr, m_addr);
         check_val("ram_we", ram_we, m_we);
         if (!m_fetch) check_val("ram_wdata", ram_wdata, m_wdata);
      end
      if (e_if_ack) check_val("if_rdata", if_rdata, e_hit ? ram_rdata : 32'h0);
      if (e_mem_ack) check_val("mem_rdata", mem_rdata, e_hit ? ram_rdata : 32'h0);
   endtask

   task automatic model_step();
      if (!m_busy) begin
         if ((mem_rd || mem_wr) && (!if_req || m_starve < int'(SL))) begin
            m_busy = 1; m_fetch = 0; m_discard = 0; m_waited = 0;
            m_starve = if_req ? m_starve + 1 : 0;
            m_addr = mem_addr; m_wdata = mem_wdata; m_we = mem_wr;
         end else if (if_req && !if_cancel) begin
            m_busy = 1; m_fetch = 1; m_discard = 0; m_waited = 0;
            m_starve = 0; m_addr = if_addr; m_we = 0;
         end
      end else if (e_done) begin
         m_busy = 0;
         if (e_tout) m_err = 1;
      end else begin
         m_waited++;
         if (m_fetch && if_cancel) m_discard = 1;
      end
   endtask

   task automatic check_reset_vals();
      check_val("rst_ram_en", ram_en, 1'b0);
      check_val("rst_if_ack", if_ack, 1'b0);
      check_val("rst_mem_ack", mem_ack, 1'b0);
      check_val("rst_bus_err", bus_err, 1'b0);
      check_val("rst_ram_addr", ram_addr, 32'h0);
      check_val("rst_ram_wdata", ram_wdata, 32'h0);
      check_val("rst_ram_we", ram_we, 1'b0);
   endtask

   initial begin
      model_reset();
      #1;
      check_reset_vals();
      repeat (2) @(negedge clk);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 300) begin
            req_pct = 100; ready_pct = 100;
         end else if (cyc < 1200) begin
            req_pct = 50; ready_pct = 50;
         end else if (cyc < 1800) begin
            req_pct = 60; ready_pct = 5;
         end else begin
            req_pct = 70; ready_pct = 30;
         end
         if (cyc == 700 || cyc == 1500 || cyc == 2200 || cyc == 2600 ||
             ($urandom_range(299) == 0)) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals();
            model_reset();
         end else begin
            rst_n = 1'b1;
            drive();
            #1;
            check_cycle();
            @(posedge clk);
            model_step();
         end
         @(negedge clk);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences each access as a multi-cycle transaction with a variable-latency ready handshake.
- Raises per-stage stall requests, which pipeline control ORs with the hazard stalls.
- Enforces MEM priority with a bounded IF-starvation guarantee, IF cancel on redirect, and a watchdog timeout.

Parameters:
STARVE_LIMIT, 4, max consecutive MEM grants while if_req is pending before IF is forced (1..15)
TIMEOUT, 64, max cycles a transaction waits for ram_ready before error abort (2..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  IF fetch request, held until if_ack
if_addr  in  32  fetch address
if_cancel  in  1  branch/jump redirect; current fetch is discarded
if_ack  out  1  fetch done; if_rdata valid this cycle
if_rdata  out  32  fetched instruction
mem_rd  in  1  load request, held until mem_ack
mem_wr  in  1  store request, held until mem_ack (never together with mem_rd)
mem_addr  in  32  data address
mem_wdata  in  32  store data
mem_ack  out  1  data access done; mem_rdata valid this cycle
mem_rdata  out  32  load data
ram_en  out  1  memory access active
ram_we  out  1  write strobe
ram_addr  out  32  latched address
ram_wdata  out  32  latched write data
ram_rdata  in  32  memory read data
ram_ready  in  1  memory completes access this cycle
if_stall  out  1  if_req & ~if_ack
mem_stall  out  1  (mem_rd|mem_wr) & ~mem_ack
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; starve_cnt=0; wait_cnt=0; bus_err=0.
  - ram_addr, ram_wdata, ram_we registers = 0.
  - All acks and ram_en = 0.
- States: IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
- IDLE grant, registered at the clock edge:
  - MEM request and (no if_req or starve_cnt<STARVE_LIMIT) -> MEM_BUSY; starve_cnt++ if if_req, else starve_cnt=0.
  - Else if_req & ~if_cancel -> IF_BUSY; starve_cnt=0.
  - The grant latches the address, write data and we; a fetch latches we=0.
- ram_en = (state != IDLE). Address, data and we are stable for the whole transaction.
- BUSY with ram_ready=1:
  - Combinational ack to the owner; rdata = ram_rdata passed through.
  - Next state is IDLE.
  - Minimum latency: request seen in cycle N, ack in N+1. One IDLE bubble follows every transaction.
- IF_BUSY with if_cancel=1:
  - The memory access is not aborted. Go to IF_DROP, or straight to IDLE if ram_ready is 1 the same cycle.
  - if_ack is suppressed for that access.
- IF_DROP: wait for ram_ready, no ack -> IDLE.
- wait_cnt:
  - Clears on every grant and increments each BUSY/DROP cycle without ram_ready.
  - At wait_cnt==TIMEOUT-1 with no ready: force the owner's ack with rdata=0, set bus_err, go to IDLE.
  - In IF_DROP a timeout sets bus_err only.
- bus_err clears only on reset.
- Simultaneous ram_ready and timeout: ready wins, normal data.
- Requests are sampled only in IDLE. Requests deasserted while BUSY do not abort the access.
- Stalls are combinational from request and ack and have no registered delay.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (2-bit);
  - STARVE_LIMIT and TIMEOUT defaults;
  - the error read-data constant 32'h0.
- One natural sub-module, mem_arb_timer: wait_cnt plus timeout compare, with clear, enable and expired ports.
- The starvation counter stays inline.

Test Plan:
- Zero-wait fetch: if_req=1, addr=0x100, ram_ready always 1 -> ram_en in cycle 1, if_ack in cycle 1, if_rdata=ram_rdata, if_stall only in cycle 0.
- Conflict: if_req and mem_rd both held, ram_ready=1, STARVE_LIMIT=4 -> 4 MEM grants, then IF granted; starve_cnt returns to 0.
- Wait states: mem_wr addr=0x2000 data=0xCAFEF00D, ram_ready after 3 cycles -> ram_we=1 and addr/data stable for 4 cycles, mem_ack on the ready cycle, mem_stall high until then.
- Cancel: if_cancel pulse in IF_BUSY with ram_ready delayed 2 cycles -> IF_DROP, no if_ack, IDLE after ready, next fetch proceeds normally.
- Timeout: ram_ready tied 0, mem_rd -> at cycle TIMEOUT mem_ack=1, mem_rdata=0, bus_err=1 and held.
- Reset mid-transaction: rst_n low in MEM_BUSY -> ram_en, acks and bus_err go 0 immediately; after release, IDLE accepts a new request.
